// File: rtl/run_sequencer.sv
// Batch run sequencer: resets a processor, launches NumProgs programs in turn,
// measures each run length until Ack and flags runs that exceed TIMEOUT.
module run_sequencer #(
    parameter int          START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'd50000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_go,
    input  logic [1:0]  i_num_progs,
    input  logic        i_ack,
    output logic        o_dut_reset,
    output logic        o_start,
    output logic [1:0]  o_prog_idx,
    output logic [15:0] o_cycle_count,
    output logic        o_result_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timed_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_DRST, S_LAUNCH, S_ARM, S_RUN, S_REPORT, S_FINISH, S_ERROR
    } state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_last_idx;
    logic [1:0]  r_prog_idx;
    logic [15:0] r_cnt;
    logic [15:0] r_lcnt;
    logic [15:0] r_cycle_count;
    logic        r_start, r_dut_reset, r_result_valid, r_done, r_timed_out;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_go) w_next = S_DRST;
            S_DRST:   w_next = S_LAUNCH;
            S_LAUNCH: if (r_lcnt == 16'(START_CYCLES - 1)) w_next = S_ARM;
            S_ARM:    w_next = S_RUN;
            // Ack wins over a timeout detected in the same cycle
            S_RUN: begin
                if (i_ack)                  w_next = S_REPORT;
                else if (r_cnt == TIMEOUT)  w_next = S_ERROR;
            end
            S_REPORT: w_next = (r_prog_idx == r_last_idx) ? S_FINISH : S_LAUNCH;
            S_FINISH: w_next = S_IDLE;
            S_ERROR:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_last_idx     <= 2'd0;
            r_prog_idx     <= 2'd0;
            r_cnt          <= 16'd0;
            r_lcnt         <= 16'd0;
            r_cycle_count  <= 16'd0;
            r_start        <= 1'b0;
            r_dut_reset    <= 1'b0;
            r_result_valid <= 1'b0;
            r_done         <= 1'b0;
            r_timed_out    <= 1'b0;
        end else begin
            r_state <= w_next;
            // Pulse outputs are registered from the next state so they line up with it
            r_start        <= (w_next == S_LAUNCH);
            r_dut_reset    <= (w_next == S_DRST) || (w_next == S_ERROR);
            r_result_valid <= (w_next == S_REPORT);
            r_done         <= (w_next == S_FINISH);

            if (r_state == S_IDLE && i_go) begin
                r_last_idx  <= i_num_progs - 2'd1;
                r_prog_idx  <= 2'd0;
                r_timed_out <= 1'b0;
            end
            if (w_next == S_ERROR)
                r_timed_out <= 1'b1;

            r_lcnt <= (r_state == S_LAUNCH) ? r_lcnt + 16'd1 : 16'd0;

            if (r_state == S_LAUNCH || r_state == S_ARM)
                r_cnt <= 16'd0;
            else if (r_state == S_RUN && !i_ack && r_cnt != 16'hFFFF)
                r_cnt <= r_cnt + 16'd1;

            if (r_state == S_RUN && i_ack)
                r_cycle_count <= r_cnt;
            if (r_state == S_REPORT && w_next == S_LAUNCH)
                r_prog_idx <= r_prog_idx + 2'd1;
        end
    end

    assign o_dut_reset    = r_dut_reset;
    assign o_start        = r_start;
    assign o_prog_idx     = r_prog_idx;
    assign o_cycle_count  = r_cycle_count;
    assign o_result_valid = r_result_valid;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = r_done;
    assign o_timed_out    = r_timed_out;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomised scoreboard bench for run_sequencer: a stimulus thread predicts the
// event stream of each batch, a monitor thread pops and compares observed events.
module tb_run_sequencer;

    localparam int          SC  = 2;
    localparam logic [15:0] TMO = 16'd100;

    localparam int EV_DRST = 0;
    localparam int EV_RES  = 1;
    localparam int EV_DONE = 2;
    localparam int EV_TMO  = 3;

    logic        clk, rst_n, go, ack;
    logic [1:0]  num_progs;
    logic        dut_reset, start, result_valid, busy, done, timed_out;
    logic [1:0]  prog_idx;
    logic [15:0] cycle_count;

    typedef struct { int kind; int idx; int cnt; } ev_t;
    ev_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    run_sequencer #(.START_CYCLES(SC), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_num_progs(num_progs), .i_ack(ack),
        .o_dut_reset(dut_reset), .o_start(start), .o_prog_idx(prog_idx),
        .o_cycle_count(cycle_count), .o_result_valid(result_valid), .o_busy(busy),
        .o_done(done), .o_timed_out(timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int idx, input int cnt);
        ev_t e;
        e.kind = kind; e.idx = idx; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int idx, input int cnt);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event: got kind %0d idx %0d cnt %0d, expected none at %0t",
                     kind, idx, cnt, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind == EV_RES && kind == EV_RES) begin
                chk("prog_idx", idx, e.idx);
                chk("cycle_count", cnt, e.cnt);
            end
        end
    endtask

    task automatic monitor();
        int sw = 0, dw = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sw = 0; dw = 0;
            end else begin
                if (start) sw++;
                else if (sw != 0) begin chk("start_width", sw, SC); sw = 0; end
                if (dut_reset) begin
                    if (dw == 0) observe(timed_out ? EV_TMO : EV_DRST, 0, 0);
                    dw++;
                end else if (dw != 0) begin chk("dut_reset_width", dw, 1); dw = 0; end
                if (result_valid) observe(EV_RES, prog_idx, cycle_count);
                if (done)         observe(EV_DONE, 0, 0);
            end
        end
    endtask

    // Returns at the negedge inside ARM (first cycle after Start drops)
    task automatic wait_arm(output bit ok);
        int t = 0;
        while (!start && t < 300) begin @(negedge clk); t++; end
        while (start && t < 300)  begin @(negedge clk); t++; end
        ok = (t < 300);
        if (!ok) begin
            checks++; failures++;
            $display("FAIL arm_wait: got no launch, expected launch within 300 cycles");
        end
    endtask

    // Holds Ack low for L run cycles then raises it; optionally pokes Go mid-run
    task automatic run_prog(input int L, input bit inject);
        @(negedge clk);
        ack = (L == 0);
        for (int i = 0; i < L; i++) begin
            go = inject && (i == 1);
            if (go) num_progs = 2'($urandom);
            @(negedge clk);
        end
        go  = 1'b0;
        ack = 1'b1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 400) begin @(negedge clk); t++; end
        chk("idle_reached", int'(t < 400), 1);
    endtask

    task automatic batch(input logic [1:0] num, input int ls[4], input bit inject);
        int  n;
        bit  ok, tmo;
        n   = (num == 2'd0) ? 4 : int'(num);
        tmo = 1'b0;
        push(EV_DRST, 0, 0);
        go = 1'b1; num_progs = num;
        @(negedge clk);
        go = 1'b0; num_progs = 2'($urandom);
        for (int k = 0; k < n; k++) begin
            wait_arm(ok);
            if (!ok) break;
            if (ls[k] > int'(TMO)) begin
                push(EV_TMO, 0, 0);
                tmo = 1'b1;
                run_prog(ls[k], 1'b0);
                break;
            end
            push(EV_RES, k, ls[k]);
            if (k == n - 1) push(EV_DONE, 0, 0);
            run_prog(ls[k], inject && k == 0);
        end
        wait_idle();
        @(negedge clk);
        chk("busy_after_batch", busy, 0);
        chk("timed_out_after_batch", timed_out, int'(tmo));
        chk("events_drained", exp_q.size(), 0);
    endtask

    task automatic reset_mid();
        bit ok;
        int ls0;
        ls0 = 4;
        push(EV_DRST, 0, 0);
        go = 1'b1; num_progs = 2'd3;
        @(negedge clk);
        go = 1'b0;
        wait_arm(ok);
        push(EV_RES, 0, ls0);
        run_prog(ls0, 1'b0);
        wait_arm(ok);
        @(negedge clk);
        ack = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", start, 0);
        chk("mid_rst_dut_reset", dut_reset, 0);
        chk("mid_rst_prog_idx", prog_idx, 0);
        chk("mid_rst_cycle_count", cycle_count, 0);
        chk("mid_rst_result_valid", result_valid, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_stays_idle", busy, 0);
        chk("mid_rst_events_drained", exp_q.size(), 0);
    endtask

    task automatic stimulus();
        int ls[4];
        ls = '{37, 0, 0, 0};           batch(2'd1, ls, 1'b0);
        ls = '{5, 12, 0, 9};           batch(2'd0, ls, 1'b0);
        ls = '{int'(TMO) + 1, 0, 0, 0}; batch(2'd1, ls, 1'b0);
        ls = '{int'(TMO), 3, 0, 0};    batch(2'd2, ls, 1'b0);
        ls = '{10, 10, 0, 0};          batch(2'd2, ls, 1'b1);
        reset_mid();
        ls = '{7, 8, 0, 0};            batch(2'd2, ls, 1'b0);
        for (int b = 0; b < 12; b++) begin
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 9))
                    0:       ls[k] = int'(TMO) + 1;
                    1:       ls[k] = int'(TMO);
                    default: ls[k] = int'($urandom_range(0, 40));
                endcase
            end
            batch(2'($urandom), ls, 1'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; ack = 1'b1; num_progs = 2'd0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        chk("rst_dut_reset", dut_reset, 0);
        chk("rst_prog_idx", prog_idx, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_timed_out", timed_out, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter START_CYCLES, default 2: number of cycles Start is held high per program launch.
REQ-002 Parameter TIMEOUT, default 16'd50000: maximum run cycles allowed before Ack.
REQ-003 Clk  input  1  clock; all state updates on posedge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Go  input  1  host request to begin a batch; sampled only in IDLE.
REQ-006 NumProgs  input  2  programs in batch; 0 encodes 4; latched when Go is accepted.
REQ-007 Ack  input  1  processor done flag.
REQ-008 DutReset  output  1  active-high reset to processor.
REQ-009 Start  output  1  processor start request.
REQ-010 ProgIdx  output  2  index of the current or just-finished program.
REQ-011 CycleCount  output  16  run length of the last finished program.
REQ-012 ResultValid  output  1  one-cycle pulse; CycleCount and ProgIdx are valid.
REQ-013 Busy  output  1  high in every state except IDLE.
REQ-014 Done  output  1  one-cycle pulse when the batch completes without timeout.
REQ-015 TimedOut  output  1  sticky error flag; cleared only by the next accepted Go or by reset.

Function
REQ-016 FSM states: IDLE, DRST, LAUNCH, ARM, RUN, REPORT, FINISH, ERROR.
REQ-017 IDLE: when Go=1, latch NumProgs, set ProgIdx=0, clear TimedOut, go to DRST.
REQ-018 DRST: DutReset=1 for exactly 1 cycle, then go to LAUNCH; this occurs only before program 0.
REQ-019 LAUNCH: Start=1 for START_CYCLES consecutive cycles, run counter cleared, then go to ARM.
REQ-020 ARM: one cycle with Start=0; Ack is ignored; counter cleared; then go to RUN.
- Ack may remain high from the previous program's halt until Start is applied.
REQ-021 RUN: counter increments by 1 per cycle while Ack=0; on the first cycle with Ack=1, go to REPORT.
- The count excludes the cycle in which Ack is sampled high.
REQ-022 Counter saturates at 16'hFFFF and does not wrap.
REQ-023 RUN timeout: if the counter reaches TIMEOUT with Ack=0, go to ERROR; Ack and timeout in the same cycle resolves as Ack (REPORT).
REQ-024 REPORT: CycleCount <= counter, ResultValid=1 for 1 cycle.
- If ProgIdx == last index (latched NumProgs-1, with 0 meaning 3), go to FINISH.
- Otherwise ProgIdx increments and the FSM goes to LAUNCH.
REQ-025 FINISH: Done=1 for 1 cycle, then IDLE.
REQ-026 ERROR: TimedOut=1, DutReset=1 for 1 cycle, then IDLE; Done and ResultValid are not asserted.
REQ-027 Go while Busy is ignored; NumProgs changes while Busy have no effect.
REQ-028 Start, DutReset, ResultValid and Done are registered outputs with no combinational path from inputs.

Reset
REQ-029 Reset=0 asynchronously forces IDLE and Start=0, DutReset=0, ProgIdx=0, CycleCount=0, ResultValid=0, Done=0, TimedOut=0, Busy=0.
REQ-030 Reset asserted mid-batch abandons the batch with no Done or ResultValid pulse; after release the FSM waits in IDLE for a new Go.

Verification
REQ-031 Go=1, NumProgs=1, Ack rises 37 cycles after ARM -> DutReset for 1 cycle; Start high for 2 cycles; ResultValid with CycleCount=37, ProgIdx=0; Done the following cycle.
REQ-032 NumProgs=0 (4 programs), Ack held high between programs -> four ResultValid pulses with ProgIdx 0,1,2,3 and no false completion during ARM; one Done.
REQ-033 TIMEOUT=100, Ack never rises -> TimedOut=1 after 100 RUN cycles; DutReset pulse; no Done; back in IDLE with Busy=0.
REQ-034 Ack rises exactly at counter=TIMEOUT -> REPORT taken, TimedOut stays 0.
REQ-035 Reset driven low during RUN of program 1 -> all outputs return to reset values immediately; a subsequent Go restarts at ProgIdx=0.
REQ-036 Go pulsed while Busy, with NumProgs changed -> batch length unchanged and no restart.
